// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes used by both the ALU controller and the execute unit,
// default datapath sizes and the MULT/DIV sequencing states.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_XOR  = 4'd1,
        OP_OR   = 4'd2,
        OP_AND  = 4'd3,
        OP_NOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SLT  = 4'd7,
        OP_ADD  = 4'd8,
        OP_ADDU = 4'd9,
        OP_SUB  = 4'd10,
        OP_SUBU = 4'd11,
        OP_MULT = 4'd12,
        OP_DIV  = 4'd13,
        OP_SRA  = 4'd14,
        OP_LUI  = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } muldiv_state_t;

    function automatic logic is_muldiv(input alu_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative signed multiply (shift-add) / divide (restoring), one step per cycle for WIDTH cycles.
// Operates on magnitudes; signs are applied on the combinational result of the final step.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             flush,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             div_mode;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] a_keep;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign last = busy && (cnt == CNT_W'(1));

    // acc_hi/acc_lo hold {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (div_mode) begin
            if (div_shift >= {1'b0, opnd}) begin
                step_hi = WIDTH'(div_shift - {1'b0, opnd});
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod   = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (div_mode) begin
            if (div_zero) begin
                res_hi = a_keep;
                res_lo = '1;
            end else begin
                res_hi = neg_rem ? -step_hi : step_hi;
                res_lo = neg_res ? -step_lo : step_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            busy     <= 1'b0;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_keep   <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= CNT_W'(WIDTH);
            div_mode <= is_div;
            neg_res  <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem  <= a[WIDTH-1];
            div_zero <= is_div && (b == '0);
            a_keep   <= a;
            opnd     <= mag(b);
            acc_hi   <= '0;
            acc_lo   <= mag(a);
        end else if (busy) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - CNT_W'(1);
            if (last) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle datapath plus FSM glue around the iterative MULT/DIV engine.
//   state | meaning
//   IDLE  | accepting ops; single-cycle results registered on the accept edge
//   MUL   | signed multiply iterating, in_ready low
//   DIV   | signed divide iterating, in_ready low
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_operation,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    alu_op_t       op;
    muldiv_state_t state, state_next;

    logic             accept;
    logic             eng_start;
    logic             eng_last;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ov;

    assign op        = alu_op_t'(alu_operation);
    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready && !flush;
    assign eng_start = accept && is_muldiv(op);
    assign sum       = a + b;
    assign dif       = a - b;

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        unique case (op)
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(b) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_ADD: begin
                alu_res = sum;
                alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = dif;
                alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: alu_res = dif;
            OP_LUI:  alu_res = b << 16;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (eng_start) state_next = (op == OP_DIV) ? DIV : MUL;
            MUL, DIV: if (flush || eng_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_next;
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_b  (rst_b),
        .flush  (flush),
        .start  (eng_start),
        .is_div (op == OP_DIV),
        .a      (a),
        .b      (b),
        .last   (eng_last),
        .res_hi (eng_hi),
        .res_lo (eng_lo)
    );

    // Flush on the final iteration edge still discards the MULT/DIV result.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (eng_last) begin
                out_valid <= 1'b1;
                hi        <= eng_hi;
                lo        <= eng_lo;
                result    <= eng_lo;
                zero      <= (eng_lo == '0);
                overflow  <= 1'b0;
            end else if (accept && !eng_start) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
                overflow  <= alu_ov;
            end
        end
    end

endmodule
